tetris_field: RTL

Parametrised Tetris playfield engine that supersedes the fixed 10×16 demo board. It keeps a COLS×ROWS occupancy map of 2-bit colour codes and runs one falling single-cell block under frame-tick gravity and player moves. It locks landed blocks, clears full rows with compaction, tracks lines and level, and serves registered pixel colours to the HDMI tile renderer through a per-cell (i_x, i_y) lookup.

---
 rtl/tetris_pkg.sv | 37 +++
 rtl/tetris_field_if.sv | 42 ++++
 rtl/tetris_gravity.sv | 51 +++++
 rtl/tetris_field.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the Tetris playfield engine.
//   state_e  : control states of the playfield sequencer
//   CODE_W   : width of one stored cell colour code (0 = empty)
//   MAX_BPP  : widest pixel the palette helper can produce
//   palette(): maps a colour code to a packed {R,G,B} pixel of bpc-bit channels
// ---------------------------------------------------------------------------
package tetris_pkg;

  typedef enum logic [2:0] {
    SPAWN,
    FALL,
    LOCK,
    CHECK,
    SHIFT,
    OVER
  } state_e;

  localparam int CODE_W  = 2;
  localparam int MAX_BPP = 48;

  // Red sits in the top channel, blue in the bottom one. Callers keep the
  // low BPP bits of the result.
  function automatic logic [MAX_BPP-1:0] palette(input logic [CODE_W-1:0] code,
                                                 input int bpc);
    logic [MAX_BPP-1:0] full;
    full = (MAX_BPP'(1) << bpc) - MAX_BPP'(1);
    case (code)
      2'd1:    palette = full << (2 * bpc);
      2'd2:    palette = full << bpc;
      2'd3:    palette = full;
      default: palette = '0;
    endcase
  endfunction

endpackage

// File: rtl/tetris_field_if.sv
// ---------------------------------------------------------------------------
// tetris_field_if
// Player, video-timing and render-lookup signals of the playfield engine.
//   i_newframe        : one-cycle pulse per video frame
//   i_x, i_y          : cell coordinate looked up by the renderer
//   i_left/right/drop : one-cycle move requests
//   o_pixel           : registered colour of cell (i_x, i_y)
//   o_lines, o_level  : cleared-row count and derived level
//   o_game_over       : high once no block can spawn
// master = the player / renderer side, slave = the playfield engine.
// ---------------------------------------------------------------------------
interface tetris_field_if #(
  parameter int COLS = 10,
  parameter int ROWS = 16,
  parameter int BPP  = 24
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic           i_newframe;
  logic [XW-1:0]  i_x;
  logic [YW-1:0]  i_y;
  logic           i_left;
  logic           i_right;
  logic           i_drop;
  logic [BPP-1:0] o_pixel;
  logic [15:0]    o_lines;
  logic [7:0]     o_level;
  logic           o_game_over;

  modport master (
    output i_newframe, i_x, i_y, i_left, i_right, i_drop,
    input  o_pixel, o_lines, o_level, o_game_over
  );

  modport slave (
    input  i_newframe, i_x, i_y, i_left, i_right, i_drop,
    output o_pixel, o_lines, o_level, o_game_over
  );

endinterface

// File: rtl/tetris_gravity.sv
// ---------------------------------------------------------------------------
// tetris_gravity
// Frame counter that paces the falling block.
//   clk_i, rst_n_i : clock and asynchronous active-low reset
//   enable_i       : high while a block is falling; counter holds otherwise
//   newframe_i     : one-cycle frame pulse
//   level_i        : current level, shortens the gravity period
//   step_o         : combinational pulse on the frame that moves the block
// The period is max(1, BASE_DELAY - level) frames.
// ---------------------------------------------------------------------------
module tetris_gravity #(
  parameter int BASE_DELAY = 100
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       newframe_i,
  input  logic [7:0] level_i,
  output logic       step_o
);

  // The counter never exceeds BASE_DELAY-1 because it clears on the step.
  localparam int CW = (BASE_DELAY < 2) ? 1 : $clog2(BASE_DELAY);

  logic [CW-1:0] frameCnt_q;
  logic [31:0]   delay;

  // Level-dependent period, clamped so gravity never stops.
  always_comb begin
    if (32'(level_i) + 32'd1 >= 32'(BASE_DELAY)) begin
      delay = 32'd1;
    end else begin
      delay = 32'(BASE_DELAY) - 32'(level_i);
    end
  end

  // ">=" rather than "==" so a level-up that shortens the period while the
  // counter is already past it still fires on the next frame.
  assign step_o = enable_i && newframe_i &&
                  (32'(frameCnt_q) + 32'd1 >= delay);

  // Count frames while falling; restart the count on every gravity step.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frameCnt_q <= '0;
    end else if (enable_i && newframe_i) begin
      frameCnt_q <= step_o ? '0 : frameCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tetris_field.sv
// ---------------------------------------------------------------------------
// tetris_field
// Tetris playfield engine: a COLS x ROWS map of 2-bit colour codes with one
// falling single-cell block, line clearing with compaction, a line/level
// count and a registered per-cell colour lookup for the tile renderer.
//   i_pixclk : sole clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : tetris_field_if slave (moves, frame pulse, lookup, status)
// Row 0 is the top of the board. Each row is packed as COLS codes, column c
// in bits [2c+1:2c].
// ---------------------------------------------------------------------------
module tetris_field
  import tetris_pkg::*;
#(
  parameter int COLS            = 10,
  parameter int ROWS            = 16,
  parameter int BPP             = 24,
  parameter int BASE_DELAY      = 100,
  parameter int LINES_PER_LEVEL = 8
) (
  input  logic          i_pixclk,
  input  logic          i_rst_n,
  tetris_field_if.slave bus
);

  localparam int XW  = $clog2(COLS);
  localparam int YW  = $clog2(ROWS);
  localparam int RW  = COLS * CODE_W;
  localparam int BPC = BPP / 3;
  localparam int LSH = $clog2(LINES_PER_LEVEL);

  localparam logic [XW-1:0] MID_X  = XW'(COLS / 2);
  localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(ROWS - 1);

  state_e             state_q;
  logic [RW-1:0]      board_q [ROWS];
  logic [XW-1:0]      fx_q;
  logic [YW-1:0]      fy_q;
  logic [CODE_W-1:0]  fc_q;
  logic [YW-1:0]      scan_q;
  logic [YW-1:0]      shift_q;
  logic [15:0]        lines_q;
  logic [7:0]         level_q;
  logic               gameOver_q;
  logic [BPP-1:0]     pixel_q;
  logic [BPP-1:0]     pixel_d;

  logic               inFall;
  logic               gravStep;
  logic               stepReq;
  logic               atBottom;
  logic               belowOcc;
  logic               leftOk;
  logic               rightOk;
  logic               spawnOcc;
  logic               scanFull;
  logic [YW-1:0]      belowY;
  logic [XW-1:0]      leftX;
  logic [XW-1:0]      rightX;
  logic [15:0]        linesInc;
  logic [15:0]        levelWide;
  logic [7:0]         levelNext;
  logic               inRange;
  logic [CODE_W-1:0]  pixCode;
  logic [MAX_BPP-1:0] palWide;

  function automatic logic [CODE_W-1:0] cellOf(input logic [RW-1:0] row,
                                               input logic [XW-1:0] x);
    int idx;
    idx = int'(x) * CODE_W;
    return row[idx +: CODE_W];
  endfunction

  assign inFall = (state_q == FALL);

  tetris_gravity #(
    .BASE_DELAY (BASE_DELAY)
  ) uGravity (
    .clk_i      (i_pixclk),
    .rst_n_i    (i_rst_n),
    .enable_i   (inFall),
    .newframe_i (bus.i_newframe),
    .level_i    (level_q),
    .step_o     (gravStep)
  );

  // Neighbour lookups around the falling block. Indices are clamped at the
  // board edges so no lookup ever leaves the array; the edge flags then
  // veto the move.
  assign atBottom = (fy_q == LAST_Y);
  assign belowY   = atBottom ? fy_q : fy_q + 1'b1;
  assign leftX    = (fx_q == '0) ? fx_q : fx_q - 1'b1;
  assign rightX   = (fx_q == LAST_X) ? fx_q : fx_q + 1'b1;
  assign belowOcc = (cellOf(board_q[belowY], fx_q) != '0);
  assign leftOk   = (fx_q != '0) && (cellOf(board_q[fy_q], leftX) == '0);
  assign rightOk  = (fx_q != LAST_X) && (cellOf(board_q[fy_q], rightX) == '0);
  assign spawnOcc = (cellOf(board_q[0], MID_X) != '0);
  assign stepReq  = gravStep || bus.i_drop;

  // A row is full when none of its cells holds the empty code.
  always_comb begin
    scanFull = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (board_q[scan_q][c*CODE_W +: CODE_W] == '0) begin
        scanFull = 1'b0;
      end
    end
  end

  // Line count saturates; level follows it with its own saturation.
  always_comb begin
    linesInc  = (lines_q == 16'hFFFF) ? lines_q : lines_q + 16'd1;
    levelWide = linesInc >> LSH;
    levelNext = (levelWide > 16'd255) ? 8'hFF : levelWide[7:0];
  end

  // Render lookup: the falling block overlays the board only while it is
  // actually falling, and coordinates beyond the board read as black.
  always_comb begin
    inRange = (int'(bus.i_x) < COLS) && (int'(bus.i_y) < ROWS);
    pixCode = '0;
    if (inRange) begin
      if (inFall && (bus.i_x == fx_q) && (bus.i_y == fy_q)) begin
        pixCode = fc_q;
      end else begin
        pixCode = cellOf(board_q[bus.i_y], bus.i_x);
      end
    end
    palWide = palette(pixCode, BPC);
    pixel_d = palWide[BPP-1:0];
  end

  // Playfield sequencer. Compaction walks from the cleared row up to row 1,
  // pulling each row down one cycle at a time, then blanks row 0 and goes
  // back to CHECK on the same row, which now holds what used to sit above.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SPAWN;
      for (int r = 0; r < ROWS; r++) begin
        board_q[r] <= '0;
      end
      fx_q       <= '0;
      fy_q       <= '0;
      fc_q       <= '0;
      scan_q     <= '0;
      shift_q    <= '0;
      lines_q    <= '0;
      level_q    <= '0;
      gameOver_q <= 1'b0;
    end else begin
      case (state_q)
        SPAWN: begin
          fx_q <= MID_X;
          fy_q <= '0;
          fc_q <= (fc_q == 2'd3) ? 2'd1 : fc_q + 2'd1;
          if (spawnOcc) begin
            state_q    <= OVER;
            gameOver_q <= 1'b1;
          end else begin
            state_q <= FALL;
          end
        end
        FALL: begin
          if (stepReq) begin
            if (atBottom || belowOcc) begin
              state_q <= LOCK;
            end else begin
              fy_q <= fy_q + 1'b1;
            end
          end else if (bus.i_left && !bus.i_right) begin
            if (leftOk) begin
              fx_q <= leftX;
            end
          end else if (bus.i_right && !bus.i_left) begin
            if (rightOk) begin
              fx_q <= rightX;
            end
          end
        end
        LOCK: begin
          board_q[fy_q][int'(fx_q)*CODE_W +: CODE_W] <= fc_q;
          scan_q  <= fy_q;
          state_q <= CHECK;
        end
        CHECK: begin
          if (scanFull) begin
            shift_q <= scan_q;
            state_q <= SHIFT;
          end else begin
            state_q <= SPAWN;
          end
        end
        SHIFT: begin
          if (shift_q != '0) begin
            board_q[shift_q] <= board_q[shift_q - 1'b1];
            shift_q          <= shift_q - 1'b1;
          end else begin
            board_q[0] <= '0;
            lines_q    <= linesInc;
            level_q    <= levelNext;
            state_q    <= CHECK;
          end
        end
        OVER: begin
          state_q <= OVER;
        end
        default: begin
          state_q <= SPAWN;
        end
      endcase
    end
  end

  // Registered render output, one cycle behind the lookup coordinate.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign bus.o_pixel     = pixel_q;
  assign bus.o_lines     = lines_q;
  assign bus.o_level     = level_q;
  assign bus.o_game_over = gameOver_q;

endmodule
